// File: rtl/shift_unit_pkg.sv
// rtl/shift_unit_pkg.sv - opcode encoding and widths shared by the shift unit and the ALU decoder
package shift_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS = 3'd0,
        OP_SLL  = 3'd1,
        OP_SRL  = 3'd2,
        OP_SLA  = 3'd3,
        OP_SRA  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

endpackage

// File: rtl/shift_unit_stage.sv
// rtl/shift_unit_stage.sv - one barrel stage: conditional shift by SHAMT plus its valid/hold register
// Carry/zero flags are built only when SHIFT_UNIT_FLAGS_EN is defined.
module shift_unit_stage
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2W = $clog2(WIDTH),
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  op_t              up_op,
    input  logic [LOG2W-1:0] up_amt,
    input  logic             up_err,
`ifdef SHIFT_UNIT_FLAGS_EN
    input  logic             up_carry,
    output logic             dn_carry,
    output logic             dn_zero,
`endif
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output op_t              dn_op,
    output logic [LOG2W-1:0] dn_amt,
    output logic             dn_err
);

    localparam int SHAMT = 1 << K;

    logic [WIDTH-1:0] shifted;
    logic             err_next;

    always_comb begin
        shifted  = up_data;
        err_next = up_err;
        if (up_op == OP_RSVD) begin
            shifted  = '0;
            err_next = 1'b1;
        end else if (up_amt[K]) begin
            case (up_op)
                OP_SLL, OP_SLA: shifted = up_data << SHAMT;
                OP_SRL:         shifted = up_data >> SHAMT;
                OP_SRA:         shifted = $unsigned($signed(up_data) >>> SHAMT);
                OP_ROL:         shifted = (up_data << SHAMT) | (up_data >> (WIDTH - SHAMT));
                OP_ROR:         shifted = (up_data >> SHAMT) | (up_data << (WIDTH - SHAMT));
                default:        shifted = up_data;
            endcase
        end
    end

    // Load when empty or when the downstream side takes our current content.
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_op    <= OP_PASS;
            dn_amt   <= '0;
            dn_err   <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= shifted;
                dn_op   <= up_op;
                dn_amt  <= up_amt;
                dn_err  <= err_next;
            end
        end
    end

`ifdef SHIFT_UNIT_FLAGS_EN
    // The last stage that actually moves bits defines the carry; idle stages pass it on.
    logic carry_next;

    always_comb begin
        carry_next = up_carry;
        if (up_op == OP_RSVD) begin
            carry_next = 1'b0;
        end else if (up_amt[K]) begin
            case (up_op)
                OP_SLL, OP_SLA: carry_next = up_data[WIDTH-SHAMT];
                OP_SRL, OP_SRA: carry_next = up_data[SHAMT-1];
                OP_ROL:         carry_next = shifted[0];
                OP_ROR:         carry_next = shifted[WIDTH-1];
                default:        carry_next = up_carry;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_carry <= 1'b0;
            dn_zero  <= 1'b0;
        end else if (up_ready && up_valid) begin
            dn_carry <= carry_next;
            dn_zero  <= (shifted == '0);
        end
    end
`endif

endmodule

// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined shift/rotate unit, one barrel stage per amount bit
// Optional carry/zero flags are enabled by defining SHIFT_UNIT_FLAGS_EN.
module shift_unit_pipe
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]  in_op,
    input  logic [LOG2W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
`ifdef SHIFT_UNIT_FLAGS_EN
    ,
    output logic             out_carry,
    output logic             out_zero
`endif
);

    // Index k is the input side of stage k; index LOG2W is the output register.
    logic             valid_p [0:LOG2W];
    logic             ready_p [0:LOG2W];
    logic [WIDTH-1:0] data_p  [0:LOG2W];
    op_t              op_p    [0:LOG2W];
    logic [LOG2W-1:0] amt_p   [0:LOG2W];
    logic             err_p   [0:LOG2W];
`ifdef SHIFT_UNIT_FLAGS_EN
    logic             carry_p [0:LOG2W];
    logic             zero_p  [1:LOG2W];
`endif

    assign valid_p[0]     = in_valid;
    assign data_p[0]      = in_data;
    assign op_p[0]        = op_t'(in_op);
    assign amt_p[0]       = in_amt;
    assign err_p[0]       = 1'b0;
    assign ready_p[LOG2W] = out_ready;

    assign in_ready  = ready_p[0];
    assign out_valid = valid_p[LOG2W];
    assign out_data  = data_p[LOG2W];
    assign out_err   = err_p[LOG2W];

`ifdef SHIFT_UNIT_FLAGS_EN
    assign carry_p[0] = 1'b0;
    assign out_carry  = carry_p[LOG2W];
    assign out_zero   = zero_p[LOG2W];
`endif

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        shift_unit_stage #(
            .WIDTH (WIDTH),
            .LOG2W (LOG2W),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (valid_p[k]),
            .up_ready (ready_p[k]),
            .up_data  (data_p[k]),
            .up_op    (op_p[k]),
            .up_amt   (amt_p[k]),
            .up_err   (err_p[k]),
`ifdef SHIFT_UNIT_FLAGS_EN
            .up_carry (carry_p[k]),
            .dn_carry (carry_p[k+1]),
            .dn_zero  (zero_p[k+1]),
`endif
            .dn_valid (valid_p[k+1]),
            .dn_ready (ready_p[k+1]),
            .dn_data  (data_p[k+1]),
            .dn_op    (op_p[k+1]),
            .dn_amt   (amt_p[k+1]),
            .dn_err   (err_p[k+1])
        );
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb/tb_shift_unit_pipe.sv - scoreboard bench for shift_unit_pipe (WIDTH=8), optional SHIFT_UNIT_FLAGS_EN
module tb_shift_unit_pipe;
    import shift_unit_pkg::*;

    localparam int WIDTH = 8;
    localparam int LOG2W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [2:0]       in_op = '0;
    logic [LOG2W-1:0] in_amt = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
`ifdef SHIFT_UNIT_FLAGS_EN
    logic             out_carry;
    logic             out_zero;
`endif

    shift_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef SHIFT_UNIT_FLAGS_EN
        ,
        .out_carry (out_carry),
        .out_zero  (out_zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       carry;
        logic       zero;
        int         acc;
        bit         lat;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        logic [2:0] a;
        logic [7:0] r;
        logic       e;
        logic       c;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operand value.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a);
        exp_t e;
        int v, p, r, sv, c;
        v = int'(d);
        p = 1 << a;
        r = 0;
        c = 0;
        e.err = 1'b0;
        case (op)
            3'd0: r = v;
            3'd1, 3'd3: begin
                r = (v * p) % 256;
                if (a != 0) c = ((v * p) / 256) % 2;
            end
            3'd2: begin
                r = v / p;
                if (a != 0) c = (v / (p / 2)) % 2;
            end
            3'd4: begin
                sv = d[7] ? v - 256 : v;
                r  = (sv >>> a) & 255;
                if (a != 0) c = (v / (p / 2)) % 2;
            end
            3'd5: begin
                r = ((v * p) % 256) + v / (256 / p);
                if (a != 0) c = r % 2;
            end
            3'd6: begin
                r = v / p + (v % p) * (256 / p);
                if (a != 0) c = r / 128;
            end
            default: begin
                r = 0;
                e.err = 1'b1;
            end
        endcase
        e.data  = r[7:0];
        e.carry = c[0];
        e.zero  = (r == 0);
        e.acc   = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    function automatic logic [10:0] snap();
`ifdef SHIFT_UNIT_FLAGS_EN
        return {out_data, out_err, out_carry, out_zero};
`else
        return {out_data, out_err, 2'b00};
`endif
    endfunction

    task automatic drive_cycle();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a,
                        input exp_t e, input bit lat);
        exp_t ee;
        ee = e;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        for (int g = 0; g < 200; g++) begin
            drive_cycle();
            #1;
            if (in_ready) begin
                ee.acc = cyc;
                ee.lat = lat;
                sb.push_back(ee);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles required 1");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            drive_cycle();
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && g < 100) begin
            drive_cycle();
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
        end
    endtask

    // Monitor: pops and compares whenever a result transfers; checks stall stability.
    initial begin
        logic [10:0] held;
        bit          stall;
        exp_t        e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (!in_ready) check("in_ready_low_only_when_full", sb.size(), LOG2W);
            if (stall) begin
                check("stall_valid_held", out_valid, 1);
                if (out_valid) check("stall_outputs_stable", snap(), held);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data 0x%0h required no result", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_err", out_err, e.err);
`ifdef SHIFT_UNIT_FLAGS_EN
                    check("out_carry", out_carry, e.carry);
                    check("out_zero", out_zero, e.zero);
`endif
                    if (e.lat) check("latency", cyc - e.acc, LOG2W);
                end
            end
            stall = out_valid && !out_ready;
            held  = snap();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion required $finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [2:0] op;
        logic [7:0] d;
        logic [2:0] a;

        vt.push_back('{3'd1, 8'hB5, 3'd3, 8'hA8, 1'b0, 1'b1});
        vt.push_back('{3'd4, 8'h96, 3'd2, 8'hE5, 1'b0, 1'b1});
        vt.push_back('{3'd2, 8'h96, 3'd2, 8'h25, 1'b0, 1'b1});
        vt.push_back('{3'd3, 8'h96, 3'd1, 8'h2C, 1'b0, 1'b1});
        vt.push_back('{3'd5, 8'h96, 3'd3, 8'hB4, 1'b0, 1'b0});
        vt.push_back('{3'd6, 8'h96, 3'd3, 8'hD2, 1'b0, 1'b1});
        vt.push_back('{3'd7, 8'hFF, 3'd0, 8'h00, 1'b1, 1'b0});
        vt.push_back('{3'd7, 8'hFF, 3'd5, 8'h00, 1'b1, 1'b0});
        vt.push_back('{3'd0, 8'h96, 3'd5, 8'h96, 1'b0, 1'b0});
        for (int o = 1; o <= 6; o++) vt.push_back('{3'(o), 8'h96, 3'd0, 8'h96, 1'b0, 1'b0});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_err", out_err, 0);
`ifdef SHIFT_UNIT_FLAGS_EN
        check("reset_out_carry", out_carry, 0);
        check("reset_out_zero", out_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Directed vectors back-to-back with out_ready high: exact latency and full throughput
        out_ready = 1'b1;
        foreach (vt[i]) begin
            e.data  = vt[i].r;
            e.err   = vt[i].e;
            e.carry = vt[i].c;
            e.zero  = (vt[i].r == 8'h00);
            send(vt[i].op, vt[i].d, vt[i].a, e, 1'b1);
        end
        drain();
        idle(3);

        // Random stream with pseudo-random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            op = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            a  = 3'($urandom_range(0, 7));
            send(op, d, a, model(op, d, a), 1'b0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
        idle(3);

        // Reset with three operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(1, 255));
            send(3'd0, d, 3'd0, model(3'd0, d, 3'd0), 1'b0);
        end
        in_valid = 1'b0;
        #1;
        check("full_before_reset_valid", out_valid, 1);
        check("full_before_reset_in_ready", in_ready, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_out_err", out_err, 0);
`ifdef SHIFT_UNIT_FLAGS_EN
        check("midreset_out_carry", out_carry, 0);
        check("midreset_out_zero", out_zero, 0);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_out_valid", out_valid, 0);
        @(negedge clk);
        d = 8'h96;
        send(3'd6, d, 3'd3, model(3'd6, d, 3'd3), 1'b1);
        drain();
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
